// File: rtl/seven_segment_display_mux.sv
// Multiplexed common-anode seven-segment driver with a sequential double-dabble binary-to-BCD converter.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_segment_display_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int VALUE_WIDTH  = 16,
  parameter int COUNT_PERIOD = 100000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   value_valid_in,
  output logic                   ready_out,
  output logic                   overflow_out,
  output logic [6:0]             cat_out,
  output logic [NUM_DIGITS-1:0]  an_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SH_W  = $clog2(VALUE_WIDTH + 1);
  localparam int CNT_W = $clog2(COUNT_PERIOD);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] CAT_DASH  = 7'b0111111;
  localparam logic [6:0] CAT_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  conv_state_e            state_q, state_d;
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       bcd_adj;
  logic [SH_W-1:0]        shift_cnt_q, shift_cnt_d;
  logic                   sticky_q, sticky_d;
  logic [BCD_W-1:0]       disp_q, disp_d;
  logic                   disp_ready_q, disp_ready_d;
  logic                   overflow_q, overflow_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [6:0]             cat_q, cat_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [NUM_DIGITS-1:0]  lead_blank;
  logic                   lz_run;
  logic [3:0]             sel_nib;
  logic                   sel_blank;

  // Active-high segment pattern, bit0 = a; 10..15 are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    shift_cnt_d  = shift_cnt_q;
    sticky_d     = sticky_q;
    disp_d       = disp_q;
    disp_ready_d = disp_ready_q;
    overflow_d   = overflow_q;
    bcd_adj      = '0;
    lead_blank   = '0;
    lz_run       = 1'b1;
    sel_nib      = 4'd0;
    sel_blank    = 1'b0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    case (state_q)
      CONV_IDLE: begin
        if (value_valid_in && ready_q) begin
          bin_d       = value_in;
          bcd_d       = '0;
          sticky_d    = 1'b0;
          shift_cnt_d = '0;
          state_d     = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        // A carry out of the top nibble means the value needs more digits than we have.
        bcd_d       = {bcd_adj[BCD_W-2:0], bin_q[VALUE_WIDTH-1]};
        bin_d       = bin_q << 1;
        sticky_d    = sticky_q | bcd_adj[BCD_W-1];
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == SH_W'(VALUE_WIDTH - 1)) state_d = CONV_COMMIT;
      end
      CONV_COMMIT: begin
        disp_d       = bcd_q;
        overflow_d   = sticky_q;
        disp_ready_d = 1'b1;
        state_d      = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase

    ready_d = (state_d == CONV_IDLE);

    if (cnt_q == CNT_W'(COUNT_PERIOD - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; digit 0 is never blanked.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run        = lz_run && (disp_q[4*i +: 4] == 4'd0);
      lead_blank[i] = lz_run;
    end
`else
    lead_blank = '0;
`endif

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        sel_nib   = disp_q[4*i +: 4];
        sel_blank = lead_blank[i];
      end
    end

    if (!disp_ready_q || overflow_q) cat_d = CAT_DASH;
    else if (sel_blank)              cat_d = CAT_BLANK;
    else                             cat_d = ~seg_decode(sel_nib);

    an_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= CONV_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      shift_cnt_q  <= '0;
      sticky_q     <= 1'b0;
      disp_q       <= '0;
      disp_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      cat_q        <= CAT_DASH;
      an_q         <= ~NUM_DIGITS'(1);
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      shift_cnt_q  <= shift_cnt_d;
      sticky_q     <= sticky_d;
      disp_q       <= disp_d;
      disp_ready_q <= disp_ready_d;
      overflow_q   <= overflow_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      cat_q        <= cat_d;
      an_q         <= an_d;
    end
  end

  assign ready_out    = ready_q;
  assign overflow_out = overflow_q;
  assign cat_out      = cat_q;
  assign an_out       = an_q;

endmodule

// File: tb/tb_seven_segment_display_mux.sv
// Bench for seven_segment_display_mux: an 8-digit and a 4-digit instance sharing clock and reset.
module tb_seven_segment_display_mux;
  localparam int W  = 16;
  localparam int CP = 4;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value8, value4;
  logic        valid8, valid4;
  logic        ready8, ready4, ov8, ov4;
  logic [6:0]  cat8, cat4;
  logic [7:0]  an8;
  logic [3:0]  an4;

  logic        sel;
  logic        ready_s, ov_s;
  logic [6:0]  cat_s;
  logic [7:0]  an_s;

  logic [55:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_segment_display_mux #(.NUM_DIGITS(8), .VALUE_WIDTH(W), .COUNT_PERIOD(CP)) dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .value_in(value8), .value_valid_in(valid8),
    .ready_out(ready8), .overflow_out(ov8), .cat_out(cat8), .an_out(an8));

  seven_segment_display_mux #(.NUM_DIGITS(4), .VALUE_WIDTH(W), .COUNT_PERIOD(CP)) dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .value_in(value4), .value_valid_in(valid4),
    .ready_out(ready4), .overflow_out(ov4), .cat_out(cat4), .an_out(an4));

  assign ready_s = sel ? ready4 : ready8;
  assign ov_s    = sel ? ov4 : ov8;
  assign cat_s   = sel ? cat4 : cat8;
  assign an_s    = sel ? {4'hF, an4} : an8;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b1000000;
      1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;
      3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;
      5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;
      7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;
      default: glyph = 7'b0010000;
    endcase
  endfunction

  // Expected glyph per digit (digit i in bits [7i+6:7i]); digits beyond nd stay zero.
  function automatic logic [55:0] model(input longint v, input int nd);
    logic [55:0] res;
    longint lim, p, rest;
    logic [6:0] g;
    res = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      rest = v / p;
      if (v > lim - 1) g = DASH;
      else begin
        g = glyph(int'(rest % 10));
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (i > 0 && rest == 0) g = BLANK;
`endif
      end
      res[7*i +: 7] = g;
      p = p * 10;
    end
    return res;
  endfunction

  function automatic logic overflow_model(input longint v, input int nd);
    longint lim;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return v > lim - 1;
  endfunction

  // Watches one full rotation, then pops the expected display and compares.
  task automatic check_display(input string name);
    int nd, hits, idx, bad_onehot, bad_period;
    int cnt [8];
    logic [6:0] got [8];
    logic [55:0] gotv, e;
    nd = sel ? 4 : 8;
    bad_onehot = 0;
    bad_period = 0;
    for (int i = 0; i < 8; i++) begin cnt[i] = 0; got[i] = 7'h00; end
    for (int c = 0; c < nd * CP; c++) begin
      @(negedge clk);
      hits = 0;
      idx = 0;
      for (int i = 0; i < nd; i++) if (an_s[i] == 1'b0) begin hits++; idx = i; end
      if (hits != 1) bad_onehot++;
      else begin cnt[idx]++; got[idx] = cat_s; end
    end
    for (int i = 0; i < nd; i++) if (cnt[i] != CP) bad_period++;
    gotv = '0;
    for (int i = 0; i < 8; i++) gotv[7*i +: 7] = got[i];
    checks++;
    if (bad_onehot != 0) begin
      errors++;
      $display("FAIL %s onehot: %0d bad anode samples, required 0", name, bad_onehot);
    end
    checks++;
    if (bad_period != 0) begin
      errors++;
      $display("FAIL %s slot_len: %0d digits not lit %0d cycles per rotation", name, bad_period, CP);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s glyphs: scoreboard empty, got %h", name, gotv);
    end else begin
      e = exp_q.pop_front();
      if (gotv !== e) begin
        errors++;
        $display("FAIL %s glyphs: got %h required %h", name, gotv, e);
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (ready_s !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (ready_s !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout: ready_out=%b after %0d cycles, required 1", name, ready_s, k);
    end
  endtask

  // Drives one value, checks busy time and overflow, then leaves cat_out settled.
  task automatic send(input longint v, input string name);
    int nd, k;
    nd = sel ? 4 : 8;
    exp_q.push_back(model(v, nd));
    @(negedge clk);
    wait_ready(name);
    if (sel) begin value4 = v[15:0]; valid4 = 1'b1; end
    else     begin value8 = v[15:0]; valid8 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    valid4 = 1'b0;
    valid8 = 1'b0;
    k = 0;
    while (ready_s !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (k != W + 1) begin
      errors++;
      $display("FAIL %s latency: ready_out returned after %0d cycles, required %0d", name, k, W + 1);
    end
    checks++;
    if (ov_s !== overflow_model(v, nd)) begin
      errors++;
      $display("FAIL %s overflow: got %b required %b", name, ov_s, overflow_model(v, nd));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0;
    valid8 = 1'b0; valid4 = 1'b0; value8 = '0; value4 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (an8 !== 8'hFE || an4 !== 4'hE) begin
      errors++;
      $display("FAIL reset_an: got %h/%h required fe/e", an8, an4);
    end
    checks++;
    if (cat8 !== DASH || cat4 !== DASH) begin
      errors++;
      $display("FAIL reset_cat: got %b/%b required %b", cat8, cat4, DASH);
    end
    checks++;
    if (ready8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b ovf=%b required 1/0", ready8, ov8);
    end
    rst_n = 1'b1;
    exp_q.push_back(model(100000000, 8));
    check_display("reset_dashes");
  endtask

  task automatic test_values();
    longint r;
    sel = 1'b0;
    send(1234, "v1234");   check_display("v1234");
    send(0, "v0");         check_display("v0");
    send(42, "v42");       check_display("v42");
    send(65535, "vmax");   check_display("vmax");
    for (int i = 0; i < 2; i++) begin
      r = longint'($urandom_range(0, 65535));
      send(r, "vrand");
      check_display("vrand");
    end
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    send(12345, "ovf12345"); check_display("ovf12345");
    send(9999, "ovf9999");   check_display("ovf9999");
    send(10000, "ovf10000"); check_display("ovf10000");
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k, idx;
    logic [55:0] e;
    sel = 1'b0;
    exp_q.push_back(model(5, 8));
    exp_q.push_back(model(7, 8));
    @(negedge clk);
    wait_ready("b2b");
    value8 = 16'd5;
    valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value8 = 16'd7;
    k = 0;
    while (ready8 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (k != W + 1) begin
      errors++;
      $display("FAIL b2b_gap: second accept possible after %0d cycles, required %0d", k, W + 1);
    end
    @(negedge clk);
    valid8 = 1'b0;
    checks++;
    if (ready8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept7: ready_out=%b, required 0 after back-to-back accept", ready8);
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (an8[i] == 1'b0) idx = i;
    e = exp_q.pop_front();
    checks++;
    if (cat8 !== e[7*idx +: 7]) begin
      errors++;
      $display("FAIL b2b_show5: digit %0d cat %b required %b", idx, cat8, e[7*idx +: 7]);
    end
    wait_ready("b2b7");
    @(negedge clk);
    check_display("b2b_show7");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    @(negedge clk);
    wait_ready("mid");
    value8 = 16'd4321;
    valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid8 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (an8 !== 8'hFE || cat8 !== DASH || ready8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%h cat=%b ready=%b ovf=%b required fe/%b/1/0",
               an8, cat8, ready8, ov8, DASH);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    exp_q.push_back(model(100000000, 8));
    check_display("mid_no4321");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_values();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
